spi_regfile: RTL

Parametrised SPI slave register file and the multi-register successor of the single-register SPI write block. It oversamples an external SPI bus (mode 0, MSB first) in the `clk` domain and decodes an AW-bit command word: MSB = 1 for write, 0 for read, remaining bits = register address. It supports write and read-back of NREG registers of DW bits, with optional burst auto-increment. It sits between the board-level SPI master and the control registers of the FPGA design.

---
 rtl/spi_regfile_if.sv | 26 ++
 rtl/spi_regfile.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_if.sv
// SPI pins and register-file side outputs of spi_regfile.
// The slave modport belongs to the register file and the master modport to the bus driver.
interface spi_regfile_if #(
    parameter int DW   = 32,
    parameter int AW   = 8,
    parameter int NREG = 4
);
    logic               sclk;
    logic               mosi;
    logic               cs;
    logic               miso;
    logic [NREG*DW-1:0] out;
    logic               wr_stb;
    logic [AW-2:0]      wr_adr;
    logic               busy;

    modport master (
        output sclk, mosi, cs,
        input  miso, out, wr_stb, wr_adr, busy
    );

    modport slave (
        input  sclk, mosi, cs,
        output miso, out, wr_stb, wr_adr, busy
    );
endinterface

// File: rtl/spi_regfile.sv
// SPI mode-0 slave register file, oversampled in the clk domain.
// The command word is {R/W, address}, followed by DW-bit data words with optional auto-increment.
module spi_regfile #(
    parameter int            DW      = 32,
    parameter int            AW      = 8,
    parameter int            NREG    = 4,
    parameter logic [DW-1:0] RST_VAL = '0,
    parameter bit            BURST   = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    spi_regfile_if.slave bus
);
    localparam int CW = $clog2((AW > DW ? AW : DW) + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [1:0] sclk_s_q, mosi_s_q, cs_s_q, seen_q;
    logic       sclk_l_q, cs_l_q, arm_q;
    logic       rise_q, fall_q, csf_q, csr_q, busy_q;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DW-2:0]          rx_q, rx_d;
    logic [DW-1:0]          tx_q, tx_d;
    logic                   wr_q, wr_d;
    logic [AW-2:0]          adr_q, adr_d;
    logic                   done_q, done_d;
    logic                   miso_q, miso_d;
    logic                   wr_stb_q, wr_stb_d;
    logic [AW-2:0]          wr_adr_q, wr_adr_d;
    logic [NREG-1:0][DW-1:0] regs_q, regs_d;

    logic [DW-1:0] word, rd_cmd, rd_nxt;
    logic [AW-1:0] cmd;
    logic [AW-2:0] adr_nxt;

    // Synchronise pins; a cs fall only counts once a real cs high has been seen after reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sclk_s_q <= '0;
            mosi_s_q <= '0;
            cs_s_q   <= '1;
            seen_q   <= '0;
            sclk_l_q <= 1'b0;
            cs_l_q   <= 1'b1;
            arm_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            csf_q    <= 1'b0;
            csr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sclk_s_q <= {sclk_s_q[0], bus.sclk};
            mosi_s_q <= {mosi_s_q[0], bus.mosi};
            cs_s_q   <= {cs_s_q[0], bus.cs};
            seen_q   <= {seen_q[0], 1'b1};
            sclk_l_q <= sclk_s_q[1];
            cs_l_q   <= cs_s_q[1];
            arm_q    <= arm_q | (seen_q[1] & cs_s_q[1]);
            rise_q   <= sclk_s_q[1] & ~sclk_l_q;
            fall_q   <= ~sclk_s_q[1] & sclk_l_q;
            csf_q    <= arm_q & cs_l_q & ~cs_s_q[1];
            csr_q    <= ~cs_l_q & cs_s_q[1];
            busy_q   <= ~cs_s_q[1];
        end
    end

    // FSM, shift registers and register file state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            wr_q     <= 1'b0;
            adr_q    <= '0;
            done_q   <= 1'b0;
            miso_q   <= 1'b0;
            wr_stb_q <= 1'b0;
            wr_adr_q <= '0;
            regs_q   <= {NREG{RST_VAL}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            wr_q     <= wr_d;
            adr_q    <= adr_d;
            done_q   <= done_d;
            miso_q   <= miso_d;
            wr_stb_q <= wr_stb_d;
            wr_adr_q <= wr_adr_d;
            regs_q   <= regs_d;
        end
    end

    // Next-state: command decode, data shifting, commit and burst advance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        wr_d     = wr_q;
        adr_d    = adr_q;
        done_d   = done_q;
        miso_d   = miso_q;
        wr_stb_d = 1'b0;
        wr_adr_d = wr_adr_q;
        regs_d   = regs_q;

        word    = {rx_q, mosi_s_q[1]};
        cmd     = word[AW-1:0];
        adr_nxt = adr_q + (AW-1)'(1);
        rd_cmd  = '0;
        rd_nxt  = '0;
        for (int k = 0; k < NREG; k++) begin
            if (cmd[AW-2:0] == (AW-1)'(k)) rd_cmd = regs_q[k];
            if (adr_nxt == (AW-1)'(k)) rd_nxt = regs_q[k];
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (csf_q) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            CMD: begin
                miso_d = 1'b0;
                if (rise_q) begin
                    rx_d = word[DW-2:0];
                    if (cnt_q == CW'(AW - 1)) begin
                        wr_d    = cmd[AW-1];
                        adr_d   = cmd[AW-2:0];
                        tx_d    = rd_cmd;
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                if (done_q) begin
                    miso_d = 1'b0;
                end else begin
                    if (fall_q) begin
                        miso_d = wr_q ? 1'b0 : tx_q[DW-1];
                        tx_d   = tx_q << 1;
                    end
                    if (rise_q) begin
                        rx_d = word[DW-2:0];
                        if (cnt_q == CW'(DW - 1)) begin
                            cnt_d = '0;
                            for (int k = 0; k < NREG; k++) begin
                                if (wr_q && adr_q == (AW-1)'(k)) begin
                                    regs_d[k] = word;
                                    wr_stb_d  = 1'b1;
                                    wr_adr_d  = adr_q;
                                end
                            end
                            if (BURST) begin
                                adr_d = adr_nxt;
                                tx_d  = rd_nxt;
                            end else begin
                                done_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (csr_q) begin
            state_d = IDLE;
            miso_d  = 1'b0;
        end
    end

    assign bus.miso   = miso_q;
    assign bus.out    = regs_q;
    assign bus.wr_stb = wr_stb_q;
    assign bus.wr_adr = wr_adr_q;
    assign bus.busy   = busy_q;
endmodule
